oled_spi_receiver: RTL and testbench
====================================

// Module: oled_spi_receiver
// PURPOSE
// - Receiver end of the PmodOLED (SSD1331) serial link that oled_display drives.
// - Samples cs/sclk/sdin/d_cn and deserialises bytes MSB-first.
// - Tracks the column/row address window and rebuilds RGB565 pixel writes with their pixel index.
// - Used as an on-board link monitor/frame-buffer mirror, and as the scoreboard front-end for OLED benches.
// PARAMETERS
// WIDTH        96  display columns; pixel_index = row*WIDTH + col
// HEIGHT       64  display rows
// SYNC_STAGES  2   flip-flop stages on each asynchronous pin input (>=2)
// PORTS
// clk          in   1   system clock (100 MHz); must be >= 4x sclk frequency
// reset_n      in   1   synchronous, active-low reset
// cs           in   1   link chip select, active low (async to clk)
// sclk         in   1   link serial clock; sdin is sampled on its rising edge (async)
// sdin         in   1   link serial data, MSB first (async)
// d_cn         in   1   1 = data byte, 0 = command byte; sampled with the byte's 8th bit (async)
// cmd_valid    out  1   one-clk pulse: a command byte was received
// cmd_byte     out  8   command byte; held until the next cmd_valid
// pixel_valid  out  1   one-clk pulse: a complete 16-bit pixel was received
// pixel_data   out  16  RGB565 pixel; first data byte = [15:8]; held until the next pixel_valid
// pixel_index  out  13  index of that pixel (0..WIDTH*HEIGHT-1)
// frame_done   out  1   one-clk pulse, coincident with pixel_valid of the last pixel in the window
// byte_err     out  1   one-clk pulse: partial byte aborted, or pixel pair broken
// BEHAVIOUR
// - Reset (reset_n=0 at a clk edge):
//   - All outputs go to 0.
//   - Bit count, shift register and pending high byte are cleared.
//   - Window resets to col 0..WIDTH-1, row 0..HEIGHT-1; cursor to (0,0); parser to P_IDLE.
//   - Synchroniser flops reset to cs=1, sclk=1.
// - Input sampling:
//   - Each pin passes through SYNC_STAGES flops.
//   - sclk_rise = synchronised sclk is 1 now and was 0 on the previous clk.
//   - When sclk_rise is seen and synchronised cs=0: shift in sdin and increment the 3-bit count.
// - Byte completion:
//   - On the 8th bit, the byte and d_cn are latched. Outputs are registered on the next clk.
//   - Latency from the pin sclk edge to the valid pulse is SYNC_STAGES+2 clk.
// - Partial-byte abort:
//   - If synchronised cs rises while count != 0, the count clears and byte_err pulses. No valid pulse is produced.
//   - If cs rises in the same clk as an 8th-bit sclk_rise, the byte completes normally.
// - Data bytes: alternate high/low; the low byte produces pixel_valid.
// - Command byte while a high byte is pending: the high byte is dropped and byte_err pulses. The command is still processed.
// - Parser FSM, running on command bytes:
//   - P_IDLE: 0x15 -> P_COL_S; 0x75 -> P_ROW_S; any other byte stays in P_IDLE.
//   - P_COL_S -> P_COL_E (latch col_start) -> P_IDLE (latch col_end).
//   - P_ROW_S -> P_ROW_E (latch row_start) -> P_IDLE (latch row_end).
//   - Parameters use bits [6:0], clamped to WIDTH-1 / HEIGHT-1.
//   - When the end byte is latched, the cursor moves to (col_start, row_start).
//   - A data byte arriving in any non-IDLE state returns the FSM to P_IDLE. The partial window update is discarded and the data is processed normally.
//   - Every command byte, including parameters, also raises cmd_valid.
// - Cursor advance, after each pixel_valid:
//   - If col != col_end: col+1.
//   - Else col = col_start; then if row != row_end: row+1, else row = row_start and frame_done pulses.
// - If start > end, the end equals the start (single column/row).
// - Pixel index arithmetic: pixel_index = row*WIDTH + col, computed unsigned in 13 bits. There is no flip correction; the index is the raw controller address.
// STRUCTURE
// - Shared package oled_pkg holds:
//   - OLED_WIDTH and OLED_HEIGHT.
//   - CMD_SET_COL = 8'h15 and CMD_SET_ROW = 8'h75.
//   - The parser state encoding P_IDLE/P_COL_S/P_COL_E/P_ROW_S/P_ROW_E.
// - Sub-module oled_rx_sync: SYNC_STAGES synchroniser for cs/sclk/sdin/d_cn plus the sclk rising-edge detector.
// - Top level: deserialiser, pixel pairing, parser FSM, cursor.
// TESTING
// - Reset: reset_n=0 for 2 clk mid-stream -> all outputs 0; the next pixel lands at pixel_index 0.
// - Default window: data bytes 0xF8,0x00 -> pixel_valid, pixel_data=16'hF800, pixel_index=0.
//   - Pixel 6144 -> pixel_index=6143 with frame_done; the next pixel -> index 0.
// - Window: cmd 0x15,0x10,0x12 then 0x75,0x05,0x06 -> 6 cmd_valid pulses.
//   - 6 pixels then give indices 496,497,498,592,593,594; frame_done on 594.
// - Abort: cs low, 5 sclk edges, cs high -> byte_err=1, no valid pulse. The next full byte 0xAF (d_cn=0) -> cmd_byte=0xAF.
// - Broken pair: data 0x12, then cmd 0x15 -> byte_err and cmd_valid. The next data pair 0x34,0x56 -> pixel_data=16'h3456.
// - Clamp: 0x15,0x7F,0x05 -> col_start clamped to 95, end forced to 95; 2 pixels at row 0 -> indices 95, 95+96.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared constants, parser state encoding and index helpers for the
// SSD1331 link receiver.
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;

  localparam logic [7:0] CMD_SET_COL = 8'h15;
  localparam logic [7:0] CMD_SET_ROW = 8'h75;

  typedef enum logic [2:0] {
    P_IDLE  = 3'd0,
    P_COL_S = 3'd1,
    P_COL_E = 3'd2,
    P_ROW_S = 3'd3,
    P_ROW_E = 3'd4
  } parser_state_e;

  // Limit a 7-bit address parameter to the last valid column/row.
  function automatic logic [6:0] clamp_addr(input logic [6:0] v, input logic [6:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Raw controller address: row*width + col, unsigned, 13 bits.
  function automatic logic [12:0] pix_index(input logic [6:0] row, input logic [6:0] col,
                                            input int width);
    return 13'(13'(row) * 13'(width) + 13'(col));
  endfunction

endpackage

// File: rtl/oled_spi_receiver_if.sv
// The four PmodOLED link pins as seen between driver (master) and receiver (slave).
interface oled_spi_receiver_if;
  logic cs;
  logic sclk;
  logic sdin;
  logic d_cn;

  modport master (output cs, output sclk, output sdin, output d_cn);
  modport slave  (input cs, input sclk, input sdin, input d_cn);
endinterface

// File: rtl/oled_rx_sync.sv
// Multi-stage synchroniser for the asynchronous link pins, plus rising-edge
// detection on sclk and cs. Idle level of cs/sclk is high, so those flops
// reset to 1 to avoid a spurious edge when reset is released.
module oled_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cs_i,
  input  logic sclk_i,
  input  logic sdin_i,
  input  logic d_cn_i,
  output logic sdin_o,
  output logic dcn_o,
  output logic sclk_rise_o,
  output logic cs_rise_o,
  output logic cs_prev_o
);

  logic [STAGES-1:0] cs_q;
  logic [STAGES-1:0] sclk_q;
  logic [STAGES-1:0] sdin_q;
  logic [STAGES-1:0] dcn_q;
  logic              cs_prev_q;
  logic              sclk_prev_q;

  // Shift each pin through the synchroniser chain and keep one extra history bit for edges.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs_q        <= {STAGES{1'b1}};
      sclk_q      <= {STAGES{1'b1}};
      sdin_q      <= {STAGES{1'b0}};
      dcn_q       <= {STAGES{1'b0}};
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
    end else begin
      cs_q        <= {cs_q[STAGES-2:0], cs_i};
      sclk_q      <= {sclk_q[STAGES-2:0], sclk_i};
      sdin_q      <= {sdin_q[STAGES-2:0], sdin_i};
      dcn_q       <= {dcn_q[STAGES-2:0], d_cn_i};
      cs_prev_q   <= cs_q[STAGES-1];
      sclk_prev_q <= sclk_q[STAGES-1];
    end
  end

  assign sdin_o      = sdin_q[STAGES-1];
  assign dcn_o       = dcn_q[STAGES-1];
  assign sclk_rise_o = sclk_q[STAGES-1] & ~sclk_prev_q;
  assign cs_rise_o   = cs_q[STAGES-1] & ~cs_prev_q;
  assign cs_prev_o   = cs_prev_q;

endmodule

// File: rtl/oled_spi_receiver.sv
// SSD1331 link receiver: deserialises bytes, parses column/row window
// commands, pairs data bytes into RGB565 pixels and tracks the write cursor.
module oled_spi_receiver
  import oled_pkg::*;
#(
  parameter int WIDTH       = OLED_WIDTH,
  parameter int HEIGHT      = OLED_HEIGHT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  oled_spi_receiver_if.slave  link,
  output logic                cmd_valid,
  output logic [7:0]          cmd_byte,
  output logic                pixel_valid,
  output logic [15:0]         pixel_data,
  output logic [12:0]         pixel_index,
  output logic                frame_done,
  output logic                byte_err
);

  localparam logic [6:0] COL_MAX = 7'(WIDTH - 1);
  localparam logic [6:0] ROW_MAX = 7'(HEIGHT - 1);

  logic sdin_s, dcn_s, sclk_rise_s, cs_rise_s, cs_prev_s, shift_en_s;

  oled_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .reset_n     (reset_n),
    .cs_i        (link.cs),
    .sclk_i      (link.sclk),
    .sdin_i      (link.sdin),
    .d_cn_i      (link.d_cn),
    .sdin_o      (sdin_s),
    .dcn_o       (dcn_s),
    .sclk_rise_o (sclk_rise_s),
    .cs_rise_o   (cs_rise_s),
    .cs_prev_o   (cs_prev_s)
  );

  // Gate on the previous cs sample so a bit arriving with the cs rise still counts.
  assign shift_en_s = sclk_rise_s & ~cs_prev_s;

  // ---------------- deserialiser ----------------
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic       bdcn_q, bdcn_d;
  logic       stb_q, stb_d;
  logic       abort_q, abort_d;

  // Shift bits in, latch complete bytes, and flag bytes cut short by cs.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    bdcn_d  = bdcn_q;
    stb_d   = 1'b0;
    abort_d = 1'b0;
    if (shift_en_s) begin
      shift_d = {shift_q[6:0], sdin_s};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        stb_d  = 1'b1;
        byte_d = {shift_q[6:0], sdin_s};
        bdcn_d = dcn_s;
      end else if (cs_rise_s) begin
        cnt_d   = 3'd0;
        abort_d = 1'b1;
      end else begin
        abort_d = 1'b0;
      end
    end else if (cs_rise_s && (cnt_q != 3'd0)) begin
      cnt_d   = 3'd0;
      abort_d = 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Deserialiser state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= 3'd0;
      shift_q <= 8'h00;
      byte_q  <= 8'h00;
      bdcn_q  <= 1'b0;
      stb_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      bdcn_q  <= bdcn_d;
      stb_q   <= stb_d;
      abort_q <= abort_d;
    end
  end

  // ---------------- parser, pixel pairing, cursor ----------------
  parser_state_e state_q, state_d;
  logic        hi_pend_q, hi_pend_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic [6:0]  col_sp_q, col_sp_d, row_sp_q, row_sp_d;
  logic [6:0]  col_start_q, col_start_d, col_end_q, col_end_d;
  logic [6:0]  row_start_q, row_start_d, row_end_q, row_end_d;
  logic [6:0]  col_q, col_d, row_q, row_d;
  logic        cmd_valid_q, cmd_valid_d, pixel_valid_q, pixel_valid_d;
  logic        frame_done_q, frame_done_d, byte_err_q, byte_err_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic [15:0] pixel_data_q, pixel_data_d;
  logic [12:0] pixel_index_q, pixel_index_d;
  logic [6:0]  col_par_s, row_par_s;

  assign col_par_s = clamp_addr(byte_q[6:0], COL_MAX);
  assign row_par_s = clamp_addr(byte_q[6:0], ROW_MAX);

  // Handle each completed byte: command parsing, pixel assembly and cursor walk.
  always_comb begin
    state_d       = state_q;
    hi_pend_d     = hi_pend_q;
    hi_byte_d     = hi_byte_q;
    col_sp_d      = col_sp_q;
    row_sp_d      = row_sp_q;
    col_start_d   = col_start_q;
    col_end_d     = col_end_q;
    row_start_d   = row_start_q;
    row_end_d     = row_end_q;
    col_d         = col_q;
    row_d         = row_q;
    cmd_valid_d   = 1'b0;
    cmd_byte_d    = cmd_byte_q;
    pixel_valid_d = 1'b0;
    pixel_data_d  = pixel_data_q;
    pixel_index_d = pixel_index_q;
    frame_done_d  = 1'b0;
    byte_err_d    = abort_q;
    if (stb_q && !bdcn_q) begin
      cmd_valid_d = 1'b1;
      cmd_byte_d  = byte_q;
      if (hi_pend_q) begin
        hi_pend_d  = 1'b0;
        byte_err_d = 1'b1;
      end else begin
        hi_pend_d = 1'b0;
      end
      case (state_q)
        P_IDLE: begin
          if (byte_q == CMD_SET_COL) begin
            state_d = P_COL_S;
          end else if (byte_q == CMD_SET_ROW) begin
            state_d = P_ROW_S;
          end else begin
            state_d = P_IDLE;
          end
        end
        P_COL_S: begin
          col_sp_d = col_par_s;
          state_d  = P_COL_E;
        end
        P_COL_E: begin
          col_start_d = col_sp_q;
          col_end_d   = (col_par_s < col_sp_q) ? col_sp_q : col_par_s;
          col_d       = col_sp_q;
          row_d       = row_start_q;
          state_d     = P_IDLE;
        end
        P_ROW_S: begin
          row_sp_d = row_par_s;
          state_d  = P_ROW_E;
        end
        P_ROW_E: begin
          row_start_d = row_sp_q;
          row_end_d   = (row_par_s < row_sp_q) ? row_sp_q : row_par_s;
          col_d       = col_start_q;
          row_d       = row_sp_q;
          state_d     = P_IDLE;
        end
        default: state_d = P_IDLE;
      endcase
    end else if (stb_q) begin
      state_d = P_IDLE;
      if (!hi_pend_q) begin
        hi_pend_d = 1'b1;
        hi_byte_d = byte_q;
      end else begin
        hi_pend_d     = 1'b0;
        pixel_valid_d = 1'b1;
        pixel_data_d  = {hi_byte_q, byte_q};
        pixel_index_d = pix_index(row_q, col_q, WIDTH);
        if (col_q != col_end_q) begin
          col_d = col_q + 7'd1;
        end else begin
          col_d = col_start_q;
          if (row_q != row_end_q) begin
            row_d = row_q + 7'd1;
          end else begin
            row_d        = row_start_q;
            frame_done_d = 1'b1;
          end
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  // Parser, window, cursor and registered output state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= P_IDLE;
      hi_pend_q     <= 1'b0;
      hi_byte_q     <= 8'h00;
      col_sp_q      <= 7'd0;
      row_sp_q      <= 7'd0;
      col_start_q   <= 7'd0;
      col_end_q     <= COL_MAX;
      row_start_q   <= 7'd0;
      row_end_q     <= ROW_MAX;
      col_q         <= 7'd0;
      row_q         <= 7'd0;
      cmd_valid_q   <= 1'b0;
      cmd_byte_q    <= 8'h00;
      pixel_valid_q <= 1'b0;
      pixel_data_q  <= 16'h0000;
      pixel_index_q <= 13'd0;
      frame_done_q  <= 1'b0;
      byte_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_pend_q     <= hi_pend_d;
      hi_byte_q     <= hi_byte_d;
      col_sp_q      <= col_sp_d;
      row_sp_q      <= row_sp_d;
      col_start_q   <= col_start_d;
      col_end_q     <= col_end_d;
      row_start_q   <= row_start_d;
      row_end_q     <= row_end_d;
      col_q         <= col_d;
      row_q         <= row_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_byte_q    <= cmd_byte_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_data_q  <= pixel_data_d;
      pixel_index_q <= pixel_index_d;
      frame_done_q  <= frame_done_d;
      byte_err_q    <= byte_err_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_byte    = cmd_byte_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_data  = pixel_data_q;
  assign pixel_index = pixel_index_q;
  assign frame_done  = frame_done_q;
  assign byte_err    = byte_err_q;

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Scoreboard bench for oled_spi_receiver: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT reports them.
module tb_oled_spi_receiver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, pixel_valid, frame_done, byte_err;
  logic [7:0]  cmd_byte;
  logic [15:0] pixel_data;
  logic [12:0] pixel_index;

  oled_spi_receiver_if link ();

  oled_spi_receiver dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .link        (link),
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .pixel_valid (pixel_valid),
    .pixel_data  (pixel_data),
    .pixel_index (pixel_index),
    .frame_done  (frame_done),
    .byte_err    (byte_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0]  exp_cmd[$];
  logic [29:0] exp_pix[$];  // {frame_done, index[12:0], data[15:0]}
  int          exp_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare every output event against the scoreboard queues.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (cmd_valid) begin
        if (exp_cmd.size() == 0) begin
          n_checks++; n_fails++;
          $display("FAIL unexpected_cmd: got 0x%0h, expected no command", cmd_byte);
        end else begin
          chk("cmd_byte", {24'd0, cmd_byte}, {24'd0, exp_cmd.pop_front()});
        end
      end
      if (pixel_valid) begin
        if (exp_pix.size() == 0) begin
          n_checks++; n_fails++;
          $display("FAIL unexpected_pixel: got 0x%0h idx %0d, expected no pixel", pixel_data, pixel_index);
        end else begin
          logic [29:0] e;
          e = exp_pix.pop_front();
          chk("pixel_data", {16'd0, pixel_data}, {16'd0, e[15:0]});
          chk("pixel_index", {19'd0, pixel_index}, {19'd0, e[28:16]});
          chk("frame_done", {31'd0, frame_done}, {31'd0, e[29]});
        end
      end else if (frame_done) begin
        n_checks++; n_fails++;
        $display("FAIL frame_done_alone: got 1, expected 0 without pixel_valid");
      end
      if (byte_err) begin
        chk("byte_err_expected", {31'd0, exp_err > 0}, 32'd1);
        if (exp_err > 0) exp_err--;
      end
    end
  end

  task automatic send_bits(input logic [7:0] b, input int nbits, input logic dc);
    for (int i = 0; i < nbits; i++) begin
      link.sclk = 1'b0;
      link.sdin = b[7-i];
      link.d_cn = dc;
      #40;
      link.sclk = 1'b1;
      #40;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    @(negedge clk);
    link.cs = 1'b0;
    #40;
    send_bits(b, 8, dc);
    link.cs = 1'b1;
    #40;
  endtask

  task automatic cmd(input logic [7:0] b);
    exp_cmd.push_back(b);
    send_byte(b, 1'b0);
  endtask

  task automatic pix(input logic [15:0] d, input logic [12:0] idx, input logic fd);
    exp_pix.push_back({fd, idx, d});
    send_byte(d[15:8], 1'b1);
    send_byte(d[7:0], 1'b1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (exp_cmd.size() == 0 && exp_pix.size() == 0 && exp_err == 0) break;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk({tag, "_cmd_left"}, exp_cmd.size(), 32'd0);
    chk({tag, "_pix_left"}, exp_pix.size(), 32'd0);
    chk({tag, "_err_left"}, exp_err, 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_cmd_valid"},   {31'd0, cmd_valid},   32'd0);
    chk({tag, "_cmd_byte"},    {24'd0, cmd_byte},    32'd0);
    chk({tag, "_pixel_valid"}, {31'd0, pixel_valid}, 32'd0);
    chk({tag, "_pixel_data"},  {16'd0, pixel_data},  32'd0);
    chk({tag, "_pixel_index"}, {19'd0, pixel_index}, 32'd0);
    chk({tag, "_frame_done"},  {31'd0, frame_done},  32'd0);
    chk({tag, "_byte_err"},    {31'd0, byte_err},    32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    link.cs   = 1'b1;
    link.sclk = 1'b1;
    link.sdin = 1'b0;
    link.d_cn = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("por");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Default window, first pixel at index 0.
    pix(16'hF800, 13'd0, 1'b0);
    drain("default");

    // Last display row: indices 6048..6143, frame_done on pixel 6144.
    cmd(8'h15); cmd(8'h00); cmd(8'h5F);
    cmd(8'h75); cmd(8'h3F); cmd(8'h3F);
    for (int i = 0; i < 96; i++) begin
      pix(16'(i * 3 + 1), 13'(6048 + i), (i == 95));
    end
    cmd(8'h75); cmd(8'h00); cmd(8'h3F);
    pix(16'hA5C3, 13'd0, 1'b0);
    drain("lastrow");

    // Window cols 16..18, rows 5..6.
    cmd(8'h15); cmd(8'h10); cmd(8'h12);
    cmd(8'h75); cmd(8'h05); cmd(8'h06);
    pix(16'h0001, 13'd496, 1'b0);
    pix(16'h0002, 13'd497, 1'b0);
    pix(16'h0003, 13'd498, 1'b0);
    pix(16'h0004, 13'd592, 1'b0);
    pix(16'h0005, 13'd593, 1'b0);
    pix(16'h0006, 13'd594, 1'b1);
    drain("window");

    // Partial byte aborted by cs, then a normal command.
    exp_err++;
    @(negedge clk);
    link.cs = 1'b0;
    #40;
    send_bits(8'hFF, 5, 1'b0);
    link.cs = 1'b1;
    #80;
    cmd(8'hAF);
    drain("abort");

    // Broken pixel pair; window command aborted by the following data.
    exp_err++;
    send_byte(8'h12, 1'b1);
    cmd(8'h15);
    pix(16'h3456, 13'd496, 1'b0);
    drain("broken");

    // Reset mid-stream with a pending high byte and a partial byte.
    send_byte(8'hAA, 1'b1);
    @(negedge clk);
    link.cs = 1'b0;
    #40;
    send_bits(8'hC0, 3, 1'b1);
    do_reset();
    link.cs = 1'b1;
    #80;
    pix(16'h07E0, 13'd0, 1'b0);
    drain("midreset");

    // Column clamp: start 127 -> 95, end 5 -> forced to 95.
    cmd(8'h15); cmd(8'h7F); cmd(8'h05);
    pix(16'h001F, 13'd95, 1'b0);
    pix(16'hFFFF, 13'd191, 1'b0);
    drain("clamp");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
